// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and helpers for the elevator call scheduler: floor constants,
// controller state encoding and the nearest-call search used for SCAN ordering.
package elevator_call_scheduler_pkg;

  localparam int MAX_FLOORS = 16;

  localparam logic [3:0] FLOOR_0 = 4'b0001;
  localparam logic [3:0] FLOOR_1 = 4'b0010;
  localparam logic [3:0] FLOOR_2 = 4'b0100;
  localparam logic [3:0] FLOOR_3 = 4'b1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DWELL  = 2'd2
  } state_t;

  // One-hot of the nearest set call strictly above (up=1) or below (up=0)
  // the one-hot position pos; zero when there is none in that direction.
  function automatic logic [MAX_FLOORS-1:0] nearest_call(
    input logic [MAX_FLOORS-1:0] calls,
    input logic [MAX_FLOORS-1:0] pos,
    input logic                  up
  );
    logic [MAX_FLOORS-1:0] result;
    logic                  past;
    result = '0;
    past   = 1'b0;
    for (int k = 0; k < MAX_FLOORS; k++) begin
      int i;
      i = up ? k : (MAX_FLOORS - 1 - k);
      if (past && calls[i] && (result == '0)) result[i] = 1'b1;
      if (pos[i]) past = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/elevator_call_scheduler_call_btn_sync.sv
// Multi-flop synchroniser for the raw call buttons followed by a rising-edge
// detector, so a held button produces exactly one single-cycle pulse.
module call_btn_sync #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]             prev_q;

  // NOTE: reset is sampled on the clock edge only, so it sits inside the
  // edge-triggered block rather than in its sensitivity list.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches call-button presses and steers the floor controller in SCAN order,
// opening the door for a tick-timed dwell on each arrival at a called floor.
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int N_FLOORS    = 4,
  parameter int DWELL_TICKS = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic [N_FLOORS-1:0] present_floor,
  input  logic                one_sec_tick,
  output logic [N_FLOORS-1:0] requested_floor,
  output logic [N_FLOORS-1:0] pending_calls,
  output logic                door_open,
  output logic                dir_up,
  output logic                fault
);

  logic [N_FLOORS-1:0] btn_rise;
  state_t              state;
  logic [3:0]          dwell_cnt;

  call_btn_sync #(
    .WIDTH (N_FLOORS),
    .STAGES(SYNC_STAGES)
  ) u_call_btn_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (call_btn),
    .rise (btn_rise)
  );

  logic                floor_valid;
  logic                arrive;
  logic                dwell_press;
  logic [N_FLOORS-1:0] ahead, behind, target, clear_mask, block_mask;
  logic                target_flip;

  assign floor_valid = $onehot(present_floor);
  assign arrive      = floor_valid && (state != DWELL) && |(pending_calls & present_floor);
  assign dwell_press = floor_valid && (state == DWELL) && |(btn_rise & present_floor);
  assign clear_mask  = arrive ? present_floor : '0;
  // Presses at the present floor are swallowed while the door is (or is about to be) open.
  assign block_mask  = (floor_valid && (arrive || state == DWELL)) ? present_floor : '0;

  // NOTE: every combinational output gets a default first, so no latch is inferred.
  always_comb begin
    ahead       = N_FLOORS'(nearest_call(MAX_FLOORS'(pending_calls), MAX_FLOORS'(present_floor), dir_up));
    behind      = N_FLOORS'(nearest_call(MAX_FLOORS'(pending_calls), MAX_FLOORS'(present_floor), !dir_up));
    target      = present_floor;
    target_flip = 1'b0;
    if (ahead != '0) begin
      target = ahead;
    end else if (behind != '0) begin
      target      = behind;
      target_flip = 1'b1;
    end
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      requested_floor <= N_FLOORS'(1);
      pending_calls   <= '0;
      door_open       <= 1'b0;
      dir_up          <= 1'b1;
      fault           <= 1'b0;
      dwell_cnt       <= '0;
    end else begin
      fault         <= !floor_valid;
      pending_calls <= (pending_calls & ~clear_mask) | (btn_rise & ~block_mask);
      if (!floor_valid) begin
        requested_floor <= N_FLOORS'(1);
        state           <= IDLE;
        door_open       <= 1'b0;
      end else begin
        case (state)
          IDLE, MOVING: begin
            if (arrive) begin
              requested_floor <= present_floor;
              state           <= DWELL;
              door_open       <= 1'b1;
              dwell_cnt       <= 4'(DWELL_TICKS);
            end else begin
              requested_floor <= target;
              if (target_flip) dir_up <= !dir_up;
              if (state == IDLE && pending_calls != '0) state <= MOVING;
            end
          end
          DWELL: begin
            requested_floor <= present_floor;
            if (dwell_press) begin
              dwell_cnt <= 4'(DWELL_TICKS);
            end else if (one_sec_tick) begin
              dwell_cnt <= dwell_cnt - 4'd1;
              if (dwell_cnt == 4'd1) begin
                state     <= IDLE;
                door_open <= 1'b0;
              end
            end
          end
          default: begin
            state     <= IDLE;
            door_open <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
